uart_rx_byte: RTL
=================

# uart_rx_byte

Upstream receive stage of the UART-to-SHA path. It turns the asynchronous serial line into validated 8-bit bytes with a one-cycle strobe. It drives the byte/strobe inputs of the 512-bit block assembler directly. Fixed 8N1 framing, 16x oversampling, majority-vote bit decisions, plus framing-error and line-break handling.

## Interface
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- BAUD, 115200, line rate in bit/s
- OVERSAMPLE, 16, ticks per bit period (fixed at 16; parameter for documentation and checks only)
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-low; the only reset in the block
- rx  in  1  asynchronous serial input, idle high
- data_out  out  8  last correctly received byte; changes only together with data_ready
- data_ready  out  1  one-cycle strobe: data_out holds a new valid byte
- frame_error  out  1  one-cycle strobe: stop bit sampled low; byte discarded
- busy  out  1  high from start-bit detection until the frame ends (IDLE re-entered)

## Operation
- Input path: rx goes through a 2-FF synchronizer, reset to 1. All decisions use the synchronized value rx_s.
- Tick generator: free-running divider with TICK_DIV = CLK_FREQ/(BAUD*16), truncated (54 at default). It emits a one-clk tick when the count reaches TICK_DIV-1, then wraps to 0.
- s_cnt: 4-bit tick counter within a bit period, advancing only on ticks. It holds three samples of rx_s taken at s_cnt 7, 8 and 9. bit_val is the majority of the three samples.
- IDLE:
  - On a tick with rx_s=0, clear s_cnt and go to START.
  - busy=0.
- START:
  - At s_cnt=15: if bit_val=1 it was a false start; return to IDLE with no strobe.
  - Otherwise clear the bit index and go to DATA.
- DATA:
  - At each s_cnt=15, shift bit_val in LSB-first.
  - After the 8th bit, go to STOP.
- STOP: evaluated at s_cnt=9, right after the third sample, which leaves half a bit of margin for the next start edge.
  - If bit_val=1: load data_out, pulse data_ready, go to IDLE.
  - If bit_val=0: pulse frame_error and keep data_out unchanged. Go to BREAK if rx_s=0, otherwise to IDLE.
- BREAK: wait until rx_s=1, then go to IDLE. No strobes while held low, so a break produces exactly one frame_error.
- Strobes are mutually exclusive and never asserted on consecutive cycles.
- Downstream has no back-pressure. Bytes are produced at most once per 10 bit times, and the consumer must accept every strobe.

## Timing
- Reset (rst=0 at a clk edge):
  - data_out=8'h00, data_ready=0, frame_error=0, busy=0.
  - FSM goes to IDLE. Synchronizer, tick divider, s_cnt and shift register are cleared; the synchronizer clears to 1.
- Reset mid-frame aborts the frame with no strobe. The next falling edge after release is treated as a fresh start.
- Input latency is 2 clk of synchronizer plus up to one tick of start-detect uncertainty (≤1/16 bit).
- data_ready / frame_error are registered: high the clk after the STOP decision tick, for exactly 1 clk.
- Frame decode time from start-bit edge to strobe is about 9.56 bit periods (start + 8 data + 9/16 stop).
- busy rises the clk after start detection. It falls in the same cycle IDLE is re-entered.
- Back-to-back frames with exactly one stop bit must be received without loss. Tolerated baud mismatch is ±3%.

## Structure
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, STOP, BREAK)
  - constant OVERSAMPLE=16
  - sample indices 7/8/9 and the end-of-bit index 15
  - function computing TICK_DIV from CLK_FREQ/BAUD
- One sub-module: uart_baud_tick (parameterized divider, tick output). The FSM and datapath stay in uart_rx_byte.
- Elaboration check: TICK_DIV ≥ 2.

## Test plan
Simulate with CLK_FREQ=64*BAUD, so TICK_DIV=4.
- Reset: assert rst=0 with rx=1 → all outputs 0, data_out=8'h00. Release and idle for 100 bit times → no strobes.
- Single byte: send 0xA5 8N1 → exactly one data_ready with data_out=8'hA5; busy high throughout the frame.
- Glitch: rx low for 4 ticks, then high → no strobe, busy drops within one bit time. A following 0x5A is received correctly.
- Framing error: 0x3C with stop bit 0, then line high → one frame_error, no data_ready, data_out still 8'h5A.
- Break: rx low for 20 bit times, then high, then 0x11 → exactly one frame_error, then data_ready with 8'h11.
- Throughput and reset: 64 back-to-back bytes 0x00..0x3F at BAUD+3% → 64 data_ready pulses in order, and the downstream assembler raises block_ready once. Then rst=0 during bit 4 of a frame → no strobe, and the next frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive path:
//   - state_t      : receiver FSM states
//   - OVERSAMPLE   : ticks per bit period
//   - SMP_*/BIT_END: tick indices of the three majority samples and of the bit end
//   - tick_div()   : clock-to-tick divider ratio for a given clock and baud rate
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam int OVERSAMPLE = 16;

    localparam logic [3:0] SMP_A   = 4'd7;
    localparam logic [3:0] SMP_B   = 4'd8;
    localparam logic [3:0] SMP_C   = 4'd9;
    localparam logic [3:0] BIT_END = 4'd15;

    // Truncating division: the resulting rate error is absorbed by the
    // receiver's baud tolerance.
    function automatic int tick_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
// Free-running divider producing the 16x oversampling tick.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-low reset, clears the divider
//   tick : one-clk pulse every TICK_DIV clocks (when the count is TICK_DIV-1)
module uart_baud_tick #(
    parameter int TICK_DIV = 54
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
// 8N1 UART receiver with 16x oversampling and 3-sample majority voting.
// Ports:
//   clk         : system clock
//   rst         : synchronous active-low reset (the only reset in the block)
//   rx          : asynchronous serial input, idle high
//   data_out    : last correctly received byte, updates only with data_ready
//   data_ready  : one-clk strobe, data_out holds a new byte
//   frame_error : one-clk strobe, stop bit sampled low and the byte discarded
//   busy        : high from start detection until IDLE is re-entered
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_ready,
    output logic       frame_error,
    output logic       busy
);

    localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD);

    if (TICK_DIV < 2) begin : g_div_check
        $error("uart_rx_byte: TICK_DIV must be at least 2");
    end
    if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_os_check
        $error("uart_rx_byte: OVERSAMPLE is fixed at 16");
    end

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic       rx_meta;
    logic       rx_s;
    logic       tick;

    state_t     state_q,   state_d;
    logic [3:0] s_cnt_q,   s_cnt_d;
    logic [2:0] smp_q,     smp_d;
    logic [7:0] shreg_q,   shreg_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] dout_q,    dout_d;
    logic       ready_q,   ready_d;
    logic       ferr_q,    ferr_d;
    logic       bit_val;
    logic       stop_val;

    uart_baud_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Two-flop synchronizer; resets to the idle-high line level so that
    // reset release never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign bit_val  = maj3(smp_q[0], smp_q[1], smp_q[2]);
    // The stop decision is taken on the very tick of the third sample, so
    // that sample is taken straight from the line instead of the register.
    assign stop_val = maj3(smp_q[0], smp_q[1], rx_s);

    always_comb begin
        state_d   = state_q;
        s_cnt_d   = s_cnt_q;
        smp_d     = smp_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        dout_d    = dout_q;
        ready_d   = 1'b0;
        ferr_d    = 1'b0;

        if (tick) begin
            s_cnt_d = s_cnt_q + 4'd1;
            if (s_cnt_q == SMP_A) smp_d[0] = rx_s;
            if (s_cnt_q == SMP_B) smp_d[1] = rx_s;
            if (s_cnt_q == SMP_C) smp_d[2] = rx_s;
        end

        case (state_q)
            IDLE: begin
                // Detection tick becomes tick 0 of the start bit.
                if (tick && !rx_s) begin
                    s_cnt_d = 4'd0;
                    state_d = START;
                end
            end
            START: begin
                if (tick && s_cnt_q == BIT_END) begin
                    if (bit_val) begin
                        state_d = IDLE;
                    end else begin
                        bit_idx_d = 3'd0;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (tick && s_cnt_q == BIT_END) begin
                    shreg_d   = {bit_val, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Deciding mid stop bit leaves half a bit to catch the next
                // start edge of a back-to-back frame.
                if (tick && s_cnt_q == SMP_C) begin
                    if (stop_val) begin
                        dout_d  = shreg_q;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = rx_s ? IDLE : BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            s_cnt_q   <= 4'd0;
            smp_q     <= 3'b000;
            shreg_q   <= 8'h00;
            bit_idx_q <= 3'd0;
            dout_q    <= 8'h00;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_cnt_q   <= s_cnt_d;
            smp_q     <= smp_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            dout_q    <= dout_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
        end
    end

    assign data_out    = dout_q;
    assign data_ready  = ready_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q != IDLE);

endmodule
